// File: rtl/flappy_pkg.sv
// flappy_pkg: shared Flappy Bird types and screen constants.
// BIRD_SUBPIXEL_EN widens velocity to Q8.4 and enables 4 fractional bits.
package flappy_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, FLY = 2'd1, DYING = 2'd2, GROUNDED = 2'd3} bird_state_t;
`ifdef BIRD_SUBPIXEL_EN
    localparam int FRAC_BITS = 4;
    typedef logic signed [11:0] bird_vel_t;
`else
    localparam int FRAC_BITS = 0;
    typedef logic signed [7:0] bird_vel_t;
`endif
    localparam int SCREEN_HEIGHT = 480;
    localparam int BIRD_HEIGHT = 20;
endpackage

// File: rtl/rise_detect.sv
// rise_detect: registered 1-bit rising-edge detector with async active-high reset.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic rise_o
);
    logic d_q;
    always_ff @(posedge clk or posedge reset)
        if (reset) d_q <= 1'b0;
        else d_q <= d_i;
    assign rise_o = d_i & ~d_q;
endmodule

// File: rtl/bird_controller.sv
// bird_controller: bird physics (gravity, flap, screen clamps) and bird-side state machine.
// Define BIRD_SUBPIXEL_EN for Q10.4 position / Q8.4 velocity with constants in 1/16 px.
module bird_controller
    import flappy_pkg::*;
#(
    parameter int BIRD_START_Y = 240,
    parameter int GRAVITY      = 1,
    parameter int FLAP_IMPULSE = 8,
    parameter int MAX_FALL     = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_tick,
    input  logic              start_button,
    input  logic              flap_button,
    input  logic              collision_in,
    output logic [9:0]        bird_y,
    output logic signed [7:0] bird_vy,
    output logic [1:0]        bird_state,
    output logic              hit_floor
);
    localparam int FB = FRAC_BITS;
    localparam int W = 12 + FB;
    typedef logic [9+FB:0] pos_t;
    typedef logic signed [W-1:0] wide_t;
    localparam wide_t G_C     = wide_t'(GRAVITY);
    localparam wide_t FLAP_C  = wide_t'(-FLAP_IMPULSE);
    localparam wide_t MAXF_C  = wide_t'(MAX_FALL);
    localparam wide_t FLOOR_C = wide_t'((SCREEN_HEIGHT - BIRD_HEIGHT) << FB);
    localparam pos_t  START_C = pos_t'(BIRD_START_Y << FB);

    bird_state_t state_q;
    pos_t        y_q, y_d;
    bird_vel_t   vy_q, vy_d;
    logic        pend_q, hit_q, flap_edge, flap_eff, land_d;
    wide_t       vy_g, vy_n, y_n;

    rise_detect u_flap (.clk(clk), .reset(reset), .d_i(flap_button), .rise_o(flap_edge));

    // A flap edge arriving on the tick itself is consumed; a collision discards it.
    always_comb begin
        flap_eff = (state_q == FLY) && (pend_q || flap_edge) && !collision_in;
        vy_g     = wide_t'(vy_q) + G_C;
        vy_n     = flap_eff ? FLAP_C : (vy_g > MAXF_C ? MAXF_C : vy_g);
        y_n      = wide_t'({2'b00, y_q}) + vy_n;
        land_d   = y_n >= FLOOR_C;
        y_d      = land_d ? pos_t'(FLOOR_C) : (y_n < 0 ? '0 : pos_t'(y_n));
        vy_d     = (land_d || y_n < 0) ? '0 : bird_vel_t'(vy_n);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            y_q     <= START_C;
            vy_q    <= '0;
            pend_q  <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    y_q    <= START_C;
                    vy_q   <= '0;
                    pend_q <= start_button;
                    if (start_button) state_q <= FLY;
                end
                FLY: begin
                    if (frame_tick) begin
                        y_q    <= y_d;
                        vy_q   <= vy_d;
                        pend_q <= 1'b0;
                        if (land_d) begin
                            hit_q   <= 1'b1;
                            state_q <= GROUNDED;
                        end else if (collision_in) state_q <= DYING;
                    end else if (collision_in) begin
                        pend_q  <= 1'b0;
                        state_q <= DYING;
                    end else if (flap_edge) pend_q <= 1'b1;
                end
                DYING: begin
                    if (frame_tick) begin
                        y_q  <= y_d;
                        vy_q <= vy_d;
                        if (land_d) begin
                            hit_q   <= 1'b1;
                            state_q <= GROUNDED;
                        end
                    end
                end
                GROUNDED: ;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bird_y     = y_q[9+FB:FB];
    assign bird_vy    = 8'(vy_q >>> FB);
    assign bird_state = state_q;
    assign hit_floor  = hit_q;
endmodule

// File: tb/tb_bird_controller.sv
// tb_bird_controller: directed + randomized checks of bird_controller against an integer model.
module tb_bird_controller;
    logic clk = 0, reset = 1, frame_tick = 0, start_button = 0, flap_button = 0, collision_in = 0;
    logic [9:0] bird_y;
    logic signed [7:0] bird_vy;
    logic [1:0] bird_state;
    logic hit_floor;
    int checks = 0, failures = 0;
    int m_y = 240, m_vy = 0, m_st = 0, m_pend = 0, m_pf = 0, m_hf = 0, m_edge;

    always #5 clk = ~clk;

    bird_controller dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start_button(start_button),
        .flap_button(flap_button), .collision_in(collision_in), .bird_y(bird_y),
        .bird_vy(bird_vy), .bird_state(bird_state), .hit_floor(hit_floor)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Physics step on plain integers: floor 460, ceiling 0.
    task automatic integrate(input int v);
        int n;
        n = m_y + v;
        if (n >= 460) begin
            m_y = 460; m_vy = 0; m_hf = 1; m_st = 3;
        end else if (n < 0) begin
            m_y = 0; m_vy = 0;
        end else begin
            m_y = n; m_vy = v;
        end
    endtask

    function automatic int fall(input int v);
        return (v + 1 > 10) ? 10 : v + 1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_y = 240; m_vy = 0; m_st = 0; m_pend = 0; m_pf = 0; m_hf = 0;
        end else begin
            m_edge = (flap_button && !m_pf) ? 1 : 0;
            m_pf = flap_button ? 1 : 0;
            if (m_st == 0) begin
                if (start_button) begin m_st = 1; m_pend = 1; end
            end else if (m_st == 1) begin
                if (frame_tick) begin
                    integrate(((m_pend || m_edge) && !collision_in) ? -8 : fall(m_vy));
                    m_pend = 0;
                    if (m_st != 3 && collision_in) m_st = 2;
                end else if (collision_in) begin
                    m_st = 2; m_pend = 0;
                end else if (m_edge) m_pend = 1;
            end else if (m_st == 2) begin
                if (frame_tick) integrate(fall(m_vy));
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("y", bird_y, m_y);
        chk("vy", bird_vy, m_vy);
        chk("state", bird_state, m_st);
        chk("hit_floor", hit_floor, m_hf);
    end

    task automatic cyc(input bit t, input bit f, input bit s, input bit c);
        frame_tick = t; flap_button = f; start_button = s; collision_in = c;
        @(posedge clk);
        #3;
    endtask

    task automatic do_reset();
        reset = 1;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        reset = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

    initial begin
        int exp_y[10];
        exp_y = '{232, 225, 219, 214, 210, 207, 205, 204, 204, 205};
        do_reset();
        repeat (5) begin
            cyc(1, 0, 0, 0);
            chk("idle_y", bird_y, 240);
            chk("idle_vy", bird_vy, 0);
            chk("idle_state", bird_state, 0);
            cyc(0, 0, 0, 0);
        end
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 0, 0, 0);
            chk("arc_y", bird_y, exp_y[i]);
            chk("arc_vy", bird_vy, i - 8);
            chk("arc_state", bird_state, 1);
        end
        repeat (9) cyc(1, 0, 0, 0);
        chk("sat_y", bird_y, 259);
        chk("sat_vy", bird_vy, 10);
        for (int i = 0; i < 60 && bird_state != 3; i++) cyc(1, 0, 0, 0);
        chk("floor_state", bird_state, 3);
        chk("floor_y", bird_y, 460);
        chk("floor_vy", bird_vy, 0);
        chk("floor_hit", hit_floor, 1);
        repeat (4) begin cyc(1, 1, 1, 0); cyc(1, 0, 0, 1); end
        chk("grounded_y", bird_y, 460);
        chk("grounded_state", bird_state, 3);

        do_reset();
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        for (int k = 2; k <= 30; k++) begin cyc(0, 1, 0, 0); cyc(1, 0, 0, 0); end
        chk("ceil_top_y", bird_y, 0);
        chk("ceil_top_vy", bird_vy, -8);
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        chk("ceil_clamp_y", bird_y, 0);
        chk("ceil_clamp_vy", bird_vy, 0);

        cyc(1, 1, 0, 1);
        chk("coll_state", bird_state, 2);
        chk("coll_vy", bird_vy, 1);
        chk("coll_y", bird_y, 1);
        cyc(0, 0, 0, 0);
        cyc(1, 1, 0, 0);
        chk("dying_vy", bird_vy, 2);
        chk("dying_y", bird_y, 3);
        for (int i = 0; i < 100 && bird_state != 3; i++) begin cyc(0, 0, 0, 0); cyc(1, 1, 0, 0); end
        chk("dying_floor_state", bird_state, 3);
        chk("dying_floor_y", bird_y, 460);
        chk("dying_floor_hit", hit_floor, 1);

        do_reset();
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("pre_reset_state", bird_state, 2);
        reset = 1;
        #2;
        chk("async_y", bird_y, 240);
        chk("async_vy", bird_vy, 0);
        chk("async_state", bird_state, 0);
        chk("async_hit", hit_floor, 0);
        cyc(0, 0, 0, 0);
        reset = 0;

        repeat (4000) begin
            reset = (bird_state == 3) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 499) == 0);
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0);
        end
        reset = 0;
        cyc(0, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bird_controller.md
Name: bird_controller

Overview:
Bird physics engine for the Flappy Bird datapath. It produces the bird's vertical position, bird_y, which the game controller and collision logic consume. On each frame tick it integrates gravity and flap impulses into the bird's velocity and position, clamps the result to the screen, and runs a bird-side state machine that mirrors game start, play and death.

Parameters:
SCREEN_HEIGHT, 480, screen height in pixels
BIRD_HEIGHT, 20, bird sprite height in pixels; floor limit is SCREEN_HEIGHT-BIRD_HEIGHT
BIRD_START_Y, 240, bird_y while idle and after reset
GRAVITY, 1, velocity increment per frame (px/frame²)
FLAP_IMPULSE, 8, flap sets velocity to -FLAP_IMPULSE
MAX_FALL, 10, maximum downward velocity (px/frame)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
frame_tick  input  1  one-cycle pulse per video frame; physics step enable
start_button  input  1  level; starts play from IDLE
flap_button  input  1  level; rising edge requests a flap
collision_in  input  1  pipe collision from the collision module
bird_y  output  10  bird top edge, pixels, unsigned
bird_vy  output  8  signed velocity, px/frame, positive = down
bird_state  output  2  IDLE=0, FLY=1, DYING=2, GROUNDED=3
hit_floor  output  1  sticky; bird reached floor

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high. Reset immediately forces:
  - bird_y=BIRD_START_Y, bird_vy=0, bird_state=IDLE, hit_floor=0
  - flap_pending=0, flap edge register=0
- Reset mid-flight behaves identically.
- Flap detect: register flap_button each clk. A rising edge sets flap_pending while in FLY. frame_tick clears it.
- Simultaneous flap edge and frame_tick: the flap is consumed on that tick.
- IDLE:
  - bird_y is held at BIRD_START_Y; bird_vy=0.
  - start_button=1 → FLY next clk, with flap_pending=1, so the first tick applies the impulse.
- FLY, on frame_tick:
  - vy_n = flap_pending ? -FLAP_IMPULSE : min(vy+GRAVITY, MAX_FALL).
  - y_n = bird_y + vy_n. Compute in 12-bit signed, semi-implicit Euler.
- Ceiling: if y_n<0 then bird_y=0 and vy=0.
- Floor: if y_n ≥ FLOOR (460 by default):
  - bird_y=FLOOR, vy=0, hit_floor=1, state→GROUNDED.
- collision_in=1 in FLY (any cycle) → DYING next clk; clears flap_pending.
  - If collision_in and floor contact fall on the same tick, floor wins (GROUNDED).
  - If collision_in and a flap fall on the same tick, collision wins and the flap is discarded.
- DYING, on frame_tick:
  - Same integration with flaps ignored; vy starts from its current value.
  - Floor contact → GROUNDED.
- GROUNDED: all outputs held; leaves only on reset.
- frame_tick outside FLY/DYING has no effect.
- Latency: outputs are registered and change on the clk edge where frame_tick=1 is sampled. They are visible the cycle after the tick.
- Illegal state encoding → IDLE.

Optional Feature:
BIRD_SUBPIXEL_EN:
- When defined, position and velocity carry 4 fractional bits internally (Q10.4, Q8.4).
- GRAVITY, FLAP_IMPULSE and MAX_FALL are then in 1/16 px units.
- bird_y outputs the integer part. bird_vy outputs the velocity arithmetic-shifted right 4.
- Clamps compare integer parts, and they zero the fraction.
- When undefined, behaviour is pure integer exactly as above.

Decomposition:
- Shared package flappy_pkg holds:
  - bird_state_t enum (IDLE, FLY, DYING, GROUNDED)
  - bird_vel_t (signed 8-bit, or 12-bit under BIRD_SUBPIXEL_EN)
  - SCREEN_HEIGHT and BIRD_HEIGHT constants shared with game_controller
- One sub-module: rise_detect (1-bit registered rising-edge detector, async active-high reset), used for flap_button.

Test Plan:
1. Reset release, 5 frame_ticks, no start → bird_y=240, bird_vy=0, bird_state=0 throughout.
2. Start pulse, then 10 ticks with no flaps:
   - bird_y: 232,225,219,214,210,207,205,204,204,205
   - bird_vy: -8..0,1
   - bird_state=1
3. Free fall from bird_y=204, vy=0:
   - vy saturates at 10 after the 10th tick.
   - Bird reaches bird_y=460, vy=0, hit_floor=1, bird_state=3.
   - Further ticks and flaps change nothing.
4. Ceiling: repeated flaps each tick from bird_y=5 → bird_y=0, bird_vy=0 on that tick; no wrap to 1023.
5. Collision and flap edge on the same tick:
   - bird_state=2; flap ignored, vy continues +1/tick.
   - Floor contact → GROUNDED.
   - Later flaps have no effect.
6. Assert reset asynchronously mid-DYING, between clk edges → outputs return to 240/0/IDLE/0 before the next clk edge.
